uart_hex_parser: RTL
====================

UART_HEX_PARSER -- requirements
Module: uart_hex_parser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: word FIFO entries; power of 2, at least 2.
REQ-002 SHALL have port clk, input, 1: rising-edge clock; single clock domain.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port rx_data, input, 8: ASCII character from the UART receive byte stream.
REQ-005 SHALL have port rx_valid, input, 1: rx_data valid this cycle; one char per pulse; no backpressure.
REQ-006 SHALL have port word_data, output, 32: FIFO head word.
REQ-007 SHALL have port word_last, output, 1: head word terminated its line.
REQ-008 SHALL have port word_valid, output, 1: FIFO non-empty.
REQ-009 SHALL have port word_ready, input, 1: consumer accept; pop when word_valid && word_ready.
REQ-010 SHALL have port err_nonhex, output, 1: sticky flag for an illegal character.
REQ-011 SHALL have port err_long, output, 1: sticky flag for a token longer than 8 digits.
REQ-012 SHALL have port err_overrun, output, 1: sticky flag for a word dropped on full FIFO.
REQ-013 SHALL have port err_clr, input, 1: clears all sticky error flags.

Function
REQ-014 SHALL decode hex chars '0'-'9', 'a'-'f', 'A'-'F' to a nibble; token delimiters are SPACE 0x20, CR 0x0D, LF 0x0A.
REQ-015 SHALL implement states IDLE (no token), DIGIT (accumulating), SKIP (discarding to LF); when rx_valid=0, no state or datapath change.
REQ-016 IDLE: hex -> acc=nibble, cnt=1, DIGIT; delimiter -> stay IDLE, no push; other -> set err_nonhex, SKIP.
REQ-017 DIGIT: hex with cnt<8 -> acc={acc[27:0],nibble}, cnt+1; hex with cnt==8 -> set err_long, drop token, SKIP.
REQ-018 DIGIT: SPACE -> push {acc,last=0}, IDLE; CR or LF -> push {acc,last=1}, IDLE; other -> set err_nonhex, drop token, SKIP.
REQ-019 SKIP: ignore all chars, CR included; LF -> IDLE; no push.
REQ-020 Tokens shorter than 8 digits SHALL be zero-extended, e.g. "1F" -> 0x0000001F.
REQ-021 A word whose line ends after a trailing SPACE SHALL keep last=0; a blank CR/LF in IDLE SHALL push nothing.
REQ-022 Push latency: word written on the clock edge that samples the terminator; word_valid high the next cycle.
REQ-023 FIFO SHALL be first-word-fall-through; word_data/word_last SHALL show the head entry and be 0 when empty.
REQ-024 Push when full without a same-cycle pop SHALL drop the word and set err_overrun; parser state advances normally.
REQ-025 Push and pop in the same cycle when full SHALL accept the push, with no overrun.
REQ-026 Pop when empty SHALL be ignored.
REQ-027 err_clr SHALL clear the flags next edge; a same-cycle new error SHALL win (flag stays set).

Reset
REQ-028 On rst: state IDLE, acc=0, cnt=0, FIFO empty, word_valid=0, word_data=0, word_last=0, all err_* = 0.
REQ-029 rst mid-token or with buffered words SHALL discard the partial token and all FIFO contents; no partial word is pushed afterwards.

Structure
REQ-030 Package uart_hex_pkg SHALL hold the state enum, ASCII constants (SPACE, CR, LF) and the hex-to-nibble/is-hex function.
REQ-031 FIFO SHALL be a sub-module uart_hex_fifo: 33-bit width, FIFO_DEPTH entries, sync reset, FWFT.

Verification
REQ-032 Bench SHALL drive "DEADBEEF 12\r\n" with word_ready=1 -> words 0xDEADBEEF last=0, then 0x00000012 last=1, no errors.
REQ-033 Bench SHALL drive "123456789 5\n" -> err_long=1, first token dropped, chars skipped to LF, no word pushed.
REQ-034 Bench SHALL drive "12G4 77\nAB\n" -> err_nonhex=1, nothing pushed before LF, then 0x000000AB last=1.
REQ-035 Bench SHALL hold word_ready=0 with FIFO_DEPTH=4 and send 5 words -> 4 buffered in order, 5th dropped, err_overrun=1; then with FIFO full, a terminator coinciding with a pop -> accepted, no new overrun.
REQ-036 Bench SHALL assert rst after "AB" of "ABCD " -> all outputs 0; then "CD " -> 0x000000CD.
REQ-037 Bench SHALL assert err_clr in the same cycle as a new illegal char -> err_nonhex stays 1; err_clr alone -> 0 next cycle.

Source files
------------

// File: rtl/uart_hex_pkg.sv
// uart_hex_pkg
// Shared definitions for the UART hex-token parser: parser state encoding,
// ASCII delimiter constants, word/FIFO widths and the hex-character decoder.
// No ports (package).
package uart_hex_pkg;

    // Parser states: no token, accumulating digits, discarding until LF.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_SKIP  = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int         WORD_W     = 32;
    localparam int         FIFO_W     = 33;   // {last, word}
    localparam logic [3:0] MAX_DIGITS = 4'd8;

    // Decoder result: is_hex qualifies nibble (nibble is 0 otherwise).
    typedef struct packed {
        logic       is_hex;
        logic [3:0] nibble;
    } hex_dec_t;

    // Map an ASCII character to its hex value; letters may be either case.
    function automatic hex_dec_t hex_decode(input logic [7:0] ch);
        hex_dec_t res;
        res.is_hex = 1'b1;
        res.nibble = 4'h0;
        if ((ch >= 8'h30) && (ch <= 8'h39)) begin
            res.nibble = ch[3:0];
        end else if ((ch >= 8'h61) && (ch <= 8'h66)) begin
            // 'a'..'f' have low nibble 1..6, so +9 gives 10..15
            res.nibble = ch[3:0] + 4'd9;
        end else if ((ch >= 8'h41) && (ch <= 8'h46)) begin
            res.nibble = ch[3:0] + 4'd9;
        end else begin
            res.is_hex = 1'b0;
            res.nibble = 4'h0;
        end
        return res;
    endfunction

    // Token terminators: SPACE, CR, LF.
    function automatic logic is_delim(input logic [7:0] ch);
        return (ch == ASCII_SPACE) || (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_hex_fifo.sv
// uart_hex_fifo
// First-word-fall-through FIFO holding {last, word} entries for the parser.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_data  : write request and entry
//   i_pop           : read request (ignored when empty)
//   o_data, o_valid : head entry (0 when empty) and non-empty flag
//   o_overrun       : this cycle's push is being dropped (full, no pop)
module uart_hex_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [uart_hex_pkg::FIFO_W-1:0] i_data,
    input  logic                           i_pop,
    output logic [uart_hex_pkg::FIFO_W-1:0] o_data,
    output logic                           o_valid,
    output logic                           o_overrun
);
    import uart_hex_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [FIFO_W-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    // A pop on the same edge frees the slot the push lands in.
    assign w_push  = i_push && (!w_full || w_pop);

    assign o_overrun = i_push && w_full && !w_pop;
    assign o_valid   = !w_empty;
    assign o_data    = w_empty ? {FIFO_W{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {FIFO_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_hex_parser.sv
// uart_hex_parser
// Turns a stream of ASCII hex tokens (up to 8 digits, separated by SPACE,
// CR or LF) into 32-bit words queued in a FWFT FIFO. Illegal characters and
// over-long tokens poison the rest of the line up to LF.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   rx_data, rx_valid         : incoming character, one per valid pulse
//   word_data, word_last      : FIFO head word and its end-of-line flag
//   word_valid, word_ready    : FIFO non-empty / consumer accept
//   err_nonhex, err_long,
//   err_overrun               : sticky error flags
//   err_clr                   : clears the sticky flags
module uart_hex_parser #(
    parameter int FIFO_DEPTH = 4   // power of 2, >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] word_data,
    output logic        word_last,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        err_nonhex,
    output logic        err_long,
    output logic        err_overrun,
    input  logic        err_clr
);
    import uart_hex_pkg::*;

    state_e             r_state;
    logic [WORD_W-1:0]  r_acc;
    logic [3:0]         r_cnt;
    logic               r_err_nonhex;
    logic               r_err_long;
    logic               r_err_overrun;

    hex_dec_t           w_dec;
    logic               w_delim;
    logic               w_push;
    logic               w_last;
    logic               w_set_nonhex;
    logic               w_set_long;
    logic               w_overrun;
    logic [FIFO_W-1:0]  w_fifo_dout;
    logic               w_fifo_valid;

    assign w_dec   = hex_decode(rx_data);
    assign w_delim = is_delim(rx_data);

    // Push and error-set decisions for the character sampled this edge, so
    // the word enters the FIFO on the same edge that sees its terminator.
    always_comb begin
        w_push       = 1'b0;
        w_last       = 1'b0;
        w_set_nonhex = 1'b0;
        w_set_long   = 1'b0;
        if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dec.is_hex || w_delim) begin
                        w_set_nonhex = 1'b0;
                    end else begin
                        w_set_nonhex = 1'b1;
                    end
                end
                ST_DIGIT: begin
                    if (w_dec.is_hex) begin
                        if (r_cnt == MAX_DIGITS) begin
                            w_set_long = 1'b1;
                        end else begin
                            w_set_long = 1'b0;
                        end
                    end else if (w_delim) begin
                        w_push = 1'b1;
                        // Only CR/LF end a line; SPACE keeps last clear.
                        w_last = (rx_data != ASCII_SPACE);
                    end else begin
                        w_set_nonhex = 1'b1;
                    end
                end
                ST_SKIP: begin
                    w_push = 1'b0;
                end
                default: begin
                    w_push = 1'b0;
                end
            endcase
        end else begin
            w_push = 1'b0;
        end
    end

    // Parser FSM and digit accumulator; idle cycles change nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= {WORD_W{1'b0}};
            r_cnt   <= 4'd0;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dec.is_hex) begin
                        r_acc   <= {28'h0000000, w_dec.nibble};
                        r_cnt   <= 4'd1;
                        r_state <= ST_DIGIT;
                    end else if (!w_delim) begin
                        r_state <= ST_SKIP;
                    end
                end
                ST_DIGIT: begin
                    if (w_dec.is_hex && (r_cnt != MAX_DIGITS)) begin
                        r_acc <= {r_acc[WORD_W-5:0], w_dec.nibble};
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        // Token ends here: pushed (delimiter) or dropped.
                        r_acc   <= {WORD_W{1'b0}};
                        r_cnt   <= 4'd0;
                        r_state <= w_delim ? ST_IDLE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (rx_data == ASCII_LF) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_acc   <= {WORD_W{1'b0}};
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error on the clearing edge keeps the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_nonhex  <= 1'b0;
            r_err_long    <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_nonhex  <= w_set_nonhex | (r_err_nonhex  & ~err_clr);
            r_err_long    <= w_set_long   | (r_err_long    & ~err_clr);
            r_err_overrun <= w_overrun    | (r_err_overrun & ~err_clr);
        end
    end

    uart_hex_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_data    ({w_last, r_acc}),
        .i_pop     (word_ready),
        .o_data    (w_fifo_dout),
        .o_valid   (w_fifo_valid),
        .o_overrun (w_overrun)
    );

    assign word_data   = w_fifo_dout[WORD_W-1:0];
    assign word_last   = w_fifo_dout[WORD_W];
    assign word_valid  = w_fifo_valid;
    assign err_nonhex  = r_err_nonhex;
    assign err_long    = r_err_long;
    assign err_overrun = r_err_overrun;

endmodule
